// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-PC unit.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: next-PC select encoding, default reset/exception vectors and the
// fixed-priority source select helper.
package pc_pkg;

  // Next-PC source, listed lowest to highest priority.
  typedef enum logic [2:0] {
    SEL_SEQ = 3'd0,
    SEL_RET = 3'd1,
    SEL_JMP = 3'd2,
    SEL_BR  = 3'd3,
    SEL_EXC = 3'd4
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  // Fixed priority: exception > branch > jump > return prediction > sequential.
  // i_ret_ok must already include the "RAS not empty" qualifier.
  function automatic pc_sel_e pc_select(input logic i_exc, input logic i_br,
                                        input logic i_jmp, input logic i_ret_ok);
    pc_sel_e w_sel;
    if (i_exc)         w_sel = SEL_EXC;
    else if (i_br)     w_sel = SEL_BR;
    else if (i_jmp)    w_sel = SEL_JMP;
    else if (i_ret_ok) w_sel = SEL_RET;
    else               w_sel = SEL_SEQ;
    return w_sel;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-PC control/status bundle between the pipeline and pc_unit.
// Latency: none (wires only).
// Backpressure: PCWrite = 0 stalls the PC; ExcValid overrides the stall.
//
// master: pipeline side (drives redirect/stall/RAS controls, reads PC + flags).
// slave : pc_unit side.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             PCWrite;
  logic             ExcValid;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             JumpValid;
  logic [WIDTH-1:0] JumpTarget;
  logic             Call;
  logic [WIDTH-1:0] PushAddr;
  logic             Return;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusIncr;
  logic             RasEmpty;
  logic             RasFull;
  logic [WIDTH-1:0] Debug;

  modport master (
    output PCWrite, ExcValid, BranchTaken, BranchTarget, JumpValid, JumpTarget,
           Call, PushAddr, Return,
    input  PCResult, PCPlusIncr, RasEmpty, RasFull, Debug
  );

  modport slave (
    input  PCWrite, ExcValid, BranchTaken, BranchTarget, JumpValid, JumpTarget,
           Call, PushAddr, Return,
    output PCResult, PCPlusIncr, RasEmpty, RasFull, Debug
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack with push, pop, replace-top and flush.
// Latency: updates visible one cycle after the requesting edge; top is read combinationally.
// Backpressure: none; a push when full overwrites the oldest entry.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_pop/i_replace/
// i_flush one-hot-ish controls (flush > replace > pop > push); i_dat data to
// write; o_top entry below the pointer; o_empty/o_full decoded from the count.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_replace,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_top_idx;

  // ptr points at the next free slot, so the top lives one below it (mod DEPTH).
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (PW+1)'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_replace) begin
      // Pop and push in one cycle cancel out: pointer and count hold.
    end else if (i_pop) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      // Saturate: the write above already overwrote the oldest slot.
      if (!o_full) r_cnt <= r_cnt + (PW+1)'(1);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      if (i_replace)   r_mem[w_top_idx] <= i_dat;
      else if (i_push) r_mem[r_ptr]     <= i_dat;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with fixed-priority next-PC select and return-address prediction.
// Latency: new PC visible one cycle after the requesting edge; PCPlusIncr is combinational.
// Backpressure: PCWrite = 0 holds PC, Debug and RAS; ExcValid overrides the stall.
//
// Ports: Clk, Reset (async active-low); bus (pc_unit_if.slave) carries stall,
// redirect and RAS controls in, and PCResult/PCPlusIncr/RasEmpty/RasFull/Debug out.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned     INCR         = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  pc_unit_if.slave  bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_dbg;
  logic [WIDTH-1:0] w_pc_incr;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_en;
  pc_sel_e          w_sel;
  logic             w_ret_sel;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  logic             w_flush;

  // Wraps modulo 2^WIDTH with no overflow indication.
  assign w_pc_incr = r_pc + WIDTH'(INCR);
  assign w_en      = bus.ExcValid | bus.PCWrite;
  assign w_sel     = pc_select(bus.ExcValid, bus.BranchTaken, bus.JumpValid,
                               bus.Return & ~w_ras_empty);
  assign w_ret_sel = w_en & (w_sel == SEL_RET);

  // A call beside a selected return becomes replace-top (redirect to the old
  // top, then overwrite that slot); an exception or branch drops the call.
  assign w_flush   = bus.ExcValid;
  assign w_replace = w_ret_sel & bus.Call;
  assign w_pop     = w_ret_sel & ~bus.Call;
  assign w_push    = w_en & bus.Call & ~bus.ExcValid & ~bus.BranchTaken & ~w_ret_sel;

  always_comb begin
    w_next = w_pc_incr;
    unique case (w_sel)
      SEL_EXC: w_next = EXC_VECTOR;
      SEL_BR:  w_next = bus.BranchTarget;
      SEL_JMP: w_next = bus.JumpTarget;
      SEL_RET: w_next = w_ras_top;
      default: w_next = w_pc_incr;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc  <= RESET_VECTOR;
      r_dbg <= RESET_VECTOR;
    end else if (w_en) begin
      r_pc  <= w_next;
      r_dbg <= w_next;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk     (Clk),
    .i_rst_n   (Reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_replace (w_replace),
    .i_flush   (w_flush),
    .i_dat     (bus.PushAddr),
    .o_top     (w_ras_top),
    .o_empty   (w_ras_empty),
    .o_full    (w_ras_full)
  );

  assign bus.PCResult   = r_pc;
  assign bus.PCPlusIncr = w_pc_incr;
  assign bus.Debug      = r_dbg;
  assign bus.RasEmpty   = w_ras_empty;
  assign bus.RasFull    = w_ras_full;

endmodule
